// File: rtl/tdm_slot_demux.sv
// Receive-side slot demux for the 4:1 time-multiplexed neuron datapath.
// Optional spike flags are enabled with the TDM_SPIKE_FLAG_EN macro.
module tdm_slot_demux #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
`ifdef TDM_SPIKE_FLAG_EN
  input  logic [WIDTH-1:0] thresh,
  output logic [3:0]       spike,
`endif
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       upd,
  output logic             frame_done,
  output logic             miss
);

  logic [1:0]       sel_q, sel_d;
  logic             tag_vld;
  logic [1:0]       tag_slot;
  logic             wr;
  logic [WIDTH-1:0] ch_q [4];
  logic [WIDTH-1:0] ch_d [4];
  logic [3:0]       upd_q, upd_d;
  logic             fd_q, fd_d;
  logic             miss_q, miss_d;

  always_comb begin
    sel_d = sel_q;
    if (en) begin
      sel_d = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 2'd0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Tag pipeline: each cycle's {en, sel} travels alongside the datapath.
  if (LATENCY == 0) begin : g_lat0
    assign tag_vld  = en;
    assign tag_slot = sel_q;
  end else begin : g_pipe
    logic [LATENCY-1:0] vld_q;
    logic [1:0]         slot_q [LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
          slot_q[i] <= 2'd0;
        end
      end else begin
        vld_q[0]  <= en;
        slot_q[0] <= sel_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
          vld_q[i]  <= vld_q[i-1];
          slot_q[i] <= slot_q[i-1];
        end
      end
    end

    assign tag_vld  = vld_q[LATENCY-1];
    assign tag_slot = slot_q[LATENCY-1];
  end

  assign wr = tag_vld & in_valid;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ch_d[k] = ch_q[k];
    end
    upd_d  = 4'b0000;
    fd_d   = 1'b0;
    miss_d = miss_q;
    if (wr) begin
      ch_d[tag_slot] = din;
      upd_d          = 4'b0001 << tag_slot;
      fd_d           = (tag_slot == 2'd3);
    end else if (tag_vld) begin
      // Expected result never showed up; remember it until reset.
      miss_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        ch_q[k] <= '0;
      end
      upd_q  <= 4'b0000;
      fd_q   <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        ch_q[k] <= ch_d[k];
      end
      upd_q  <= upd_d;
      fd_q   <= fd_d;
      miss_q <= miss_d;
    end
  end

`ifdef TDM_SPIKE_FLAG_EN
  logic [3:0] spike_q, spike_d;

  always_comb begin
    spike_d = spike_q;
    if (wr) begin
      spike_d[tag_slot] = (din >= thresh);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 4'b0000;
    end else begin
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
`endif

  assign sel        = sel_q;
  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign upd        = upd_q;
  assign frame_done = fd_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_tdm_slot_demux.sv
// Scoreboard bench for tdm_slot_demux: three instances (LATENCY 0, 1, 3) share stimulus.
// Spike outputs are checked when TDM_SPIKE_FLAG_EN is defined.
module tb_tdm_slot_demux;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [1:0]      sel;
    logic [3:0][7:0] ch;
    logic [3:0]      upd;
    logic            fd;
    logic            miss;
    logic [3:0]      spike;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] din;

  logic [1:0] sel_w  [NDUT];
  logic [7:0] ch_w   [NDUT][4];
  logic [3:0] upd_w  [NDUT];
  logic       fd_w   [NDUT];
  logic       miss_w [NDUT];
`ifdef TDM_SPIKE_FLAG_EN
  logic [7:0] thresh;
  logic [3:0] spike_w [NDUT];
`endif

  int n_pass  = 0;
  int n_total = 0;

  exp_t       exp_q [NDUT][$];
  logic [2:0] hist [$];  // issued {valid, slot}, newest first
  int         m_sel;
  logic [7:0] m_ch    [NDUT][4];
  logic       m_miss  [NDUT];
  logic [3:0] m_spike [NDUT];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  tdm_slot_demux #(.WIDTH(8), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .en(en), .sel(sel_w[0]), .din(din), .in_valid(in_valid),
`ifdef TDM_SPIKE_FLAG_EN
    .thresh(thresh), .spike(spike_w[0]),
`endif
    .ch0(ch_w[0][0]), .ch1(ch_w[0][1]), .ch2(ch_w[0][2]), .ch3(ch_w[0][3]),
    .upd(upd_w[0]), .frame_done(fd_w[0]), .miss(miss_w[0])
  );

  tdm_slot_demux #(.WIDTH(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .en(en), .sel(sel_w[1]), .din(din), .in_valid(in_valid),
`ifdef TDM_SPIKE_FLAG_EN
    .thresh(thresh), .spike(spike_w[1]),
`endif
    .ch0(ch_w[1][0]), .ch1(ch_w[1][1]), .ch2(ch_w[1][2]), .ch3(ch_w[1][3]),
    .upd(upd_w[1]), .frame_done(fd_w[1]), .miss(miss_w[1])
  );

  tdm_slot_demux #(.WIDTH(8), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .en(en), .sel(sel_w[2]), .din(din), .in_valid(in_valid),
`ifdef TDM_SPIKE_FLAG_EN
    .thresh(thresh), .spike(spike_w[2]),
`endif
    .ch0(ch_w[2][0]), .ch1(ch_w[2][1]), .ch2(ch_w[2][2]), .ch3(ch_w[2][3]),
    .upd(upd_w[2]), .frame_done(fd_w[2]), .miss(miss_w[2])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s lat=%0d actual=%h required=%h", nm, lat_of(i), act, req);
    end
  endtask

  // Reference model: result due now for latency L is the tag issued L cycles ago.
  task automatic model_update();
    exp_t       x;
    logic       tv;
    logic [1:0] ts;
    if (rst) begin
      hist.delete();
      m_sel = 0;
      for (int i = 0; i < NDUT; i++) begin
        for (int k = 0; k < 4; k++) m_ch[i][k] = 8'h00;
        m_miss[i]  = 1'b0;
        m_spike[i] = 4'b0000;
        x = '0;
        exp_q[i].push_back(x);
      end
    end else begin
      hist.push_front({en, 2'(m_sel)});
      if (hist.size() > 5) void'(hist.pop_back());
      for (int i = 0; i < NDUT; i++) begin
        x  = '0;
        tv = 1'b0;
        ts = 2'd0;
        if (hist.size() > lat_of(i)) {tv, ts} = hist[lat_of(i)];
        if (tv && in_valid) begin
          m_ch[i][ts] = din;
          x.upd       = 4'(1 << ts);
          x.fd        = (ts == 2'd3);
`ifdef TDM_SPIKE_FLAG_EN
          m_spike[i][ts] = (din >= thresh);
`endif
        end else if (tv) begin
          m_miss[i] = 1'b1;
        end
        x.sel   = 2'((m_sel + (en ? 1 : 0)) % 4);
        x.ch    = {m_ch[i][3], m_ch[i][2], m_ch[i][1], m_ch[i][0]};
        x.miss  = m_miss[i];
        x.spike = m_spike[i];
        exp_q[i].push_back(x);
      end
      m_sel = (m_sel + (en ? 1 : 0)) % 4;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic iv, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    en       = e;
    in_valid = iv;
    din      = d;
`ifdef TDM_SPIKE_FLAG_EN
    thresh   = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'($urandom);
`endif
    @(posedge clk);
    model_update();
  endtask

  // Monitor: pops expectations after every active edge and compares.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        while (exp_q[i].size() > 0) begin
          x = exp_q[i].pop_front();
          chk("sel", i, 32'(sel_w[i]), 32'(x.sel));
          chk("ch", i, {ch_w[i][3], ch_w[i][2], ch_w[i][1], ch_w[i][0]}, x.ch);
          chk("upd", i, 32'(upd_w[i]), 32'(x.upd));
          chk("frame_done", i, 32'(fd_w[i]), 32'(x.fd));
          chk("miss", i, 32'(miss_w[i]), 32'(x.miss));
`ifdef TDM_SPIKE_FLAG_EN
          chk("spike", i, 32'(spike_w[i]), 32'(x.spike));
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    din      = 8'h00;
`ifdef TDM_SPIKE_FLAG_EN
    thresh   = 8'h80;
`endif
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Fill: din = 0x10 + slot due for the LATENCY=1 instance.
    for (int c = 0; c < 6; c++) begin
      d = 8'h10;
      if (hist.size() > 0) d = 8'h10 + {6'd0, hist[0][1:0]};
      step(1'b0, 1'b1, 1'b1, d);
    end
    #2;
    for (int k = 0; k < 4; k++) chk("fill_ch", 1, 32'(ch_w[1][k]), 32'(8'h10 + k));
    chk("fill_miss", 1, 32'(miss_w[1]), 32'd0);

    // en gap
    repeat (2) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'($urandom));
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'($urandom));

    // Dropped result, then sticky miss
    step(1'b0, 1'b1, 1'b0, 8'($urandom));
    repeat (10) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    #2;
    chk("miss_sticky", 1, 32'(miss_w[1]), 32'd1);
    chk("miss_sticky", 2, 32'(miss_w[2]), 32'd1);

    // Reset with tags in flight
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    #2;
    chk("rst_miss", 2, 32'(miss_w[2]), 32'd0);
    repeat (4) step(1'b0, 1'b1, 1'b1, 8'hAA);

    // Randomized traffic
    repeat (400) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) != 0, 8'($urandom));
    end
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);

    @(posedge clk);
    #2;
    for (int i = 0; i < NDUT; i++) chk("drain", i, 32'(exp_q[i].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_slot_demux.md
Name: tdm_slot_demux

Overview:
- Receive-side partner of the 4:1 8-bit time-multiplexing mux in the neuron datapath.
- Generates the slot select that drives the upstream mux.
- Tracks each slot through the shared neuron datapath's fixed pipeline latency.
- Demultiplexes the returning shared 8-bit result into four held per-neuron registers, with per-channel update strobes and a frame-complete pulse.

Parameters:
- WIDTH, 8, data width of the shared bus and of each channel register.
- LATENCY, 1, cycles from sel issue to the matching result on din; legal range 0..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance schedule; when 1, sel steps every cycle.
- sel  output  2  slot select to upstream 4:1 mux; registered.
- din  input  WIDTH  shared datapath result.
- in_valid  input  1  din carries a valid result this cycle.
- ch0, ch1, ch2, ch3  output  WIDTH each  held per-channel results.
- upd  output  4  one-cycle strobe; bit k high in the cycle chk first shows a new value.
- frame_done  output  1  one-cycle pulse coincident with upd[3].
- miss  output  1  sticky; an expected result did not arrive.

Behaviour:
- Reset (rst=1 at a clock edge):
  - sel=0, ch0..ch3=0, upd=0, frame_done=0, miss=0.
  - All tag-pipeline stages are invalidated.
  - rst has priority over every other input.
- Slot counter:
  - en=1: sel <= sel+1 mod 4 (3 wraps to 0).
  - en=0: sel holds.
- Tag pipeline:
  - Each cycle a tag {valid=en, slot=sel} enters a LATENCY-deep shift register.
  - The shift register advances every cycle regardless of en.
  - LATENCY=0: the output tag is the current {en, sel} combinationally.
- Capture, at output tag T:
  - T.valid=1 and in_valid=1: ch[T.slot] <= din, upd[T.slot] <= 1; all other upd bits <= 0.
  - T.valid=1 and in_valid=0: no write, upd <= 0, miss <= 1. miss stays set until rst.
  - T.valid=0: din and in_valid are ignored and upd <= 0. in_valid=1 here is not an error.
- frame_done <= 1 exactly when a write to slot 3 occurs; otherwise 0.
- Latency: sel=k issued at cycle t with en=1 → din sampled at t+LATENCY → chk and upd[k] visible at t+LATENCY+1.
- At most one upd bit is high in any cycle.
- Channel registers hold their value indefinitely between writes.
- en toggling:
  - Gaps propagate as invalid tags, so no write occurs for slots not issued.
  - Resumption continues from the held sel.
- Reset mid-operation: in-flight tags are dropped. No writes occur for LATENCY cycles after rst deasserts, until new tags reach the output.
- Widths: sel is 2 bits, wrapping naturally. No arithmetic on data; din is copied verbatim.

Optional Feature:
- Macro TDM_SPIKE_FLAG_EN.
- Defined:
  - Adds input thresh[WIDTH-1:0] and output spike[3:0].
  - On each write to channel k, spike[k] <= (din >= thresh), unsigned comparison.
  - spike[k] holds until the next write to channel k.
  - spike resets to 0.
- Undefined: thresh and spike ports and logic are absent; all other behaviour is identical.

Test Plan:
- LATENCY=1, rst then en=1, din = 0x10+sel delayed 1 cycle, in_valid=1 → ch0..ch3 = 0x10,0x11,0x12,0x13; upd sequence 0001,0010,0100,1000; frame_done high with upd=1000; miss=0.
- en=1 for 2 cycles, en=0 for 3 cycles, en=1 again → sel goes 0,1,2 (hold 3 cycles),3,0; only slots 0,1,2,3 written in order; no upd during the gap.
- Drop in_valid on the cycle slot 2's result is due → ch2 unchanged, upd=0 that cycle, miss=1 and still 1 after 10 more cycles; cleared only by rst.
- Assert rst while 1 tag is in flight (LATENCY=3, in_valid held 1, din=0xAA) → all outputs 0 next cycle; no write during the 3 cycles after release.
- LATENCY=0 → din presented same cycle as sel=2 with in_valid → ch2 updates next cycle.
- TDM_SPIKE_FLAG_EN, thresh=0x80, writes of 0x7F to ch0 and 0x80 to ch1 → spike=0010; a later write of 0x00 to ch1 → spike=0000.
